// File: rtl/img_xfer_pkg.sv
// Shared types and constants for the picture-transfer controller.
//   - state_t : controller FSM states (SEND_CHK only with IMG_XFER_CHECKSUM_EN)
//   - CMD_*   : single-byte command codes decoded in IDLE
//   - lane_t  : byte-lane index within a 32-bit memory word
//   - get_lane/set_lane : little-endian byte-lane access helpers
package img_xfer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;

  localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h4C;
  localparam logic [BYTE_W-1:0] CMD_SEND = 8'h53;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_RD,
    SEND_CAP,
    SEND_BYTE
`ifdef IMG_XFER_CHECKSUM_EN
    , SEND_CHK
`endif
  } state_t;

  // Byte k of a word lives in bits [8k+7:8k].
  function automatic logic [BYTE_W-1:0] get_lane(input logic [WORD_W-1:0] w, input lane_t l);
    logic [BYTE_W-1:0] b;
    case (l)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [WORD_W-1:0] set_lane(input logic [WORD_W-1:0] w, input lane_t l,
                                                 input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    case (l)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/img_xfer_ctrl.sv
// Picture-transfer controller on the byte-stream side of the UART.
// Decodes 'L' / 'S' commands from the receive strobe, packs received bytes
// into 32-bit words written to memory, and streams memory back out through
// the transmit strobe/ack handshake, LSB byte first.
// Optional macro IMG_XFER_CHECKSUM_EN adds an XOR checksum byte in both
// directions, the SEND_CHK state and the sticky chk_err output.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   rx_byte, rx_stb        received byte and its one-cycle strobe
//   tx_byte, tx_stb, tx_ack transmit byte, level request, one-cycle ack
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata  word memory port
//   busy                   high whenever not IDLE
//   load_done, send_done   end-of-transfer pulses
//   chk_err                sticky checksum mismatch (macro only)
module img_xfer_ctrl
  import img_xfer_pkg::*;
#(
  parameter int unsigned P_NUM_WORDS = 25344,
  parameter int unsigned P_ADDR_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   rx_byte,
  input  logic                rx_stb,
  output logic [BYTE_W-1:0]   tx_byte,
  output logic                tx_stb,
  input  logic                tx_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [P_ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                load_done,
`ifdef IMG_XFER_CHECKSUM_EN
  output logic                chk_err,
`endif
  output logic                send_done
);

  localparam logic [P_ADDR_W-1:0] LAST_ADDR = P_ADDR_W'(P_NUM_WORDS - 1);
  localparam logic [P_ADDR_W-1:0] ADDR_ONE  = P_ADDR_W'(1);

  state_t                state_q, state_d;
  lane_t                 lane_q, lane_d;
  logic [P_ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [BYTE_W-1:0]     tx_byte_d;
  logic                  tx_stb_d;
  logic                  mem_en_d, mem_we_d;
  logic [P_ADDR_W-1:0]   mem_addr_d;
  logic [WORD_W-1:0]     mem_wdata_d;
  logic                  busy_d, load_done_d, send_done_d;
  logic                  last_word;
`ifdef IMG_XFER_CHECKSUM_EN
  logic [BYTE_W-1:0]     xor_q, xor_d;
  logic                  chk_err_d;
  logic                  ld_chk_q, ld_chk_d;
`endif

  assign last_word = (addr_q == LAST_ADDR);

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      tx_byte   <= '0;
      tx_stb    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      send_done <= 1'b0;
`ifdef IMG_XFER_CHECKSUM_EN
      xor_q     <= '0;
      chk_err   <= 1'b0;
      ld_chk_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      tx_byte   <= tx_byte_d;
      tx_stb    <= tx_stb_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      load_done <= load_done_d;
      send_done <= send_done_d;
`ifdef IMG_XFER_CHECKSUM_EN
      xor_q     <= xor_d;
      chk_err   <= chk_err_d;
      ld_chk_q  <= ld_chk_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    word_d      = word_q;
    tx_byte_d   = tx_byte;
    tx_stb_d    = tx_stb;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    load_done_d = 1'b0;
    send_done_d = 1'b0;
`ifdef IMG_XFER_CHECKSUM_EN
    xor_d       = xor_q;
    chk_err_d   = chk_err;
    ld_chk_d    = ld_chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_stb) begin
          if (rx_byte == CMD_LOAD) begin
            state_d = LOAD;
            lane_d  = '0;
            addr_d  = '0;
`ifdef IMG_XFER_CHECKSUM_EN
            xor_d     = '0;
            chk_err_d = 1'b0;
            ld_chk_d  = 1'b0;
`endif
          end else if (rx_byte == CMD_SEND) begin
            // Read of word 0 is issued straight from the command cycle.
            state_d    = SEND_RD;
            lane_d     = '0;
            addr_d     = '0;
            mem_en_d   = 1'b1;
            mem_addr_d = '0;
`ifdef IMG_XFER_CHECKSUM_EN
            xor_d      = '0;
`endif
          end
        end
      end

      LOAD: begin
        if (rx_stb) begin
`ifdef IMG_XFER_CHECKSUM_EN
          if (ld_chk_q) begin
            // Trailing checksum byte after the last word.
            chk_err_d   = chk_err | (rx_byte != xor_q);
            load_done_d = 1'b1;
            ld_chk_d    = 1'b0;
            state_d     = IDLE;
          end else begin
            xor_d = xor_q ^ rx_byte;
`else
          begin
`endif
            word_d = set_lane(word_q, lane_q, rx_byte);
            lane_d = lane_t'(lane_q + 2'd1);
            if (lane_q == 2'd3) begin
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = set_lane(word_q, lane_q, rx_byte);
              if (last_word) begin
`ifdef IMG_XFER_CHECKSUM_EN
                ld_chk_d    = 1'b1;
`else
                load_done_d = 1'b1;
                state_d     = IDLE;
`endif
              end else begin
                addr_d = addr_q + ADDR_ONE;
              end
            end
          end
        end
      end

      SEND_RD: state_d = SEND_CAP;

      SEND_CAP: begin
        word_d    = mem_rdata;
        tx_byte_d = get_lane(mem_rdata, 2'd0);
        tx_stb_d  = 1'b1;
        lane_d    = '0;
        state_d   = SEND_BYTE;
      end

      SEND_BYTE: begin
        if (tx_stb) begin
          if (tx_ack) begin
            tx_stb_d = 1'b0;
            lane_d   = lane_t'(lane_q + 2'd1);
`ifdef IMG_XFER_CHECKSUM_EN
            xor_d    = xor_q ^ tx_byte;
`endif
            if (lane_q == 2'd3 && last_word) begin
`ifdef IMG_XFER_CHECKSUM_EN
              state_d     = SEND_CHK;
`else
              send_done_d = 1'b1;
              state_d     = IDLE;
`endif
            end
          end
        end else if (lane_q == 2'd0) begin
          // Idle lane 0 here only follows the ack of byte 3: fetch next word.
          addr_d     = addr_q + ADDR_ONE;
          mem_addr_d = addr_q + ADDR_ONE;
          mem_en_d   = 1'b1;
          state_d    = SEND_RD;
        end else begin
          tx_byte_d = get_lane(word_q, lane_q);
          tx_stb_d  = 1'b1;
        end
      end

`ifdef IMG_XFER_CHECKSUM_EN
      SEND_CHK: begin
        if (tx_stb) begin
          if (tx_ack) begin
            tx_stb_d    = 1'b0;
            send_done_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          tx_byte_d = xor_q;
          tx_stb_d  = 1'b1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
